arb4_ctrl: RTL and testbench
============================

# arb4_ctrl

Four-requester round-robin arbiter that shares one WIDTH-bit resource port (e.g., the single memory/bus port in the pipeline) among four clients. It tracks ownership with a two-state FSM and a rotating priority pointer, and bounds tenure with a hold counter. It drives the 2-bit select of a 4:1 data mux built from the existing mux4_1 cells, so the owner's data reaches the resource. Grants are registered; one owner at a time.

## Interface
Parameters:
- WIDTH, 16, data width of each requester's payload and of data_out
- MAX_HOLD, 8, maximum consecutive grant cycles while another requester waits (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per client; held high for the whole transaction
- in0  input  WIDTH  client 0 payload
- in1  input  WIDTH  client 1 payload
- in2  input  WIDTH  client 2 payload
- in3  input  WIDTH  client 3 payload
- gnt  output  4  one-hot grant, registered
- sel  output  2  index of current/last owner, registered; drives mux select
- busy  output  1  1 when any gnt bit is set
- data_out  output  WIDTH  selected payload: in[sel], combinational from registered sel

## Operation
- FSM states: IDLE (gnt=0), OWN (exactly one gnt bit set).
- Pointer `last` (2 bits) = most recent owner. Search order for a new owner: last+1, last+2, last+3, last (mod 4). The first client in that order with req=1 wins.
- IDLE: if req≠0, go to OWN with the search winner; load sel and gnt; clear hold_cnt. Otherwise stay.
- OWN, owner's req=0: release. If another req is pending, hand over directly to the search winner (OWN→OWN, no idle cycle). Otherwise go to IDLE with gnt=0, keeping sel.
- OWN, owner's req=1, another req pending, hold_cnt=MAX_HOLD-1: preempt. The grant moves to the search winner and hold_cnt clears.
- OWN, owner's req=1 otherwise: keep the grant. hold_cnt increments only while another req is pending, and clears when none is pending.
- On every grant change, `last` takes the new owner.
- hold_cnt width is clog2(MAX_HOLD)+1 bits. It never exceeds MAX_HOLD-1.
- data_out = in[sel] at all times, including IDLE. Consumers qualify it with busy.
- Reset values: gnt=4'b0000, sel=2'b00, busy=0, last=2'b11 (first search starts at client 0), hold_cnt=0, state=IDLE.

## Timing
- Grant latency: req rising in cycle N → gnt and sel valid in cycle N+1. Arbitration is sampled on the edge that ends cycle N.
- Release latency: owner drops req in cycle N → in cycle N+1 either the new owner holds gnt or gnt=0.
- Preemption: with a competitor waiting from the owner's first granted cycle, the owner holds gnt for exactly MAX_HOLD cycles.
- Simultaneous requests: resolved by pointer order only. There is no fixed priority.
- Owner drops req on the preemption edge: treated as a release. The result is the same winner.
- A req of a non-owner that pulses for one cycle can win if sampled on a decision edge. Clients must hold req until granted.
- rst asserted mid-transaction: all state returns to reset values on that edge, with gnt=0 in the next cycle regardless of req. The first grant after reset is possible one cycle after rst deasserts.
- gnt is never multi-hot, and is never set for a client whose req was 0 on the deciding edge.

## Structure
- Shared include arb_defs.vh holds:
  - the state encodings (IDLE=1'b0, OWN=1'b1);
  - the default MAX_HOLD;
  - the client index constants.
- One natural sub-module, rr_pick4: a combinational round-robin picker with inputs req[3:0] and start[1:0]; outputs idx[1:0] and found.
- The data path instantiates WIDTH copies of mux4_1 in a generate loop, all driven by sel.

## Test plan
- Reset, then req=4'b0100 held → gnt=4'b0100 and sel=2 in the next cycle, busy=1; data_out=in2.
- All four req high from idle after reset, each client dropping req after 3 granted cycles → grant order 0,1,2,3 with no idle cycles between handovers.
- MAX_HOLD=8, req0 and req1 held permanently → gnt alternates 0001 for 8 cycles, then 0010 for 8 cycles, repeating.
- Single requester req3 held for 20 cycles alone → gnt=1000 throughout with no preemption. Asserting req1 at cycle 20 yields the handover to client 1 exactly 8 cycles later.
- Owner 2 drops req while req0 is pending → next cycle gnt=0001, last=0. The next search starts at 1.
- rst pulsed for one cycle while client 1 owns the resource with req1 still high → gnt=0 and sel=0 after the reset edge; the next cycle re-grants client 1 (pointer reset to 3).

Source files
------------

// File: rtl/arb4_ctrl_pkg.sv
// arb4_ctrl_pkg: shared state encodings, client indices and defaults for the arbiter
package arb4_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    C0 = 2'd0,
    C1 = 2'd1,
    C2 = 2'd2,
    C3 = 2'd3
  } client_t;

  localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/arb4_ctrl_rr_pick4.sv
// rr_pick4: combinational round-robin picker, search order start+1, start+2, start+3, start
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] start,
  output logic [1:0] idx,
  output logic       found
);

  logic [1:0] c;

  // walk offsets from farthest to nearest so the nearest requester after start wins
  always_comb begin
    idx = start;
    found = 1'b0;
    c = '0;
    for (int k = 3; k >= 0; k--) begin
      c = start + 2'(k + 1);
      if (req[c]) begin
        idx = c;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_1.sv
// mux4_1: one-bit 4:1 multiplexer cell
module mux4_1 (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  assign y = s[1] ? (s[0] ? d[3] : d[2]) : (s[0] ? d[1] : d[0]);

endmodule

// File: rtl/arb4_ctrl.sv
// arb4_ctrl: four-client round-robin arbiter with bounded tenure driving a 4:1 data mux
module arb4_ctrl
  import arb4_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             busy,
  output logic [WIDTH-1:0] data_out
);

  localparam int HW = $clog2(MAX_HOLD) + 1;

  state_t        state;
  logic [1:0]    last;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    idx;
  logic          found;
  logic          own_req;
  logic          pending;
  logic          preempt;

  rr_pick4 u_pick (
    .req  (req),
    .start(last),
    .idx  (idx),
    .found(found)
  );

  // in IDLE gnt is zero, so own_req=0 and the release path doubles as the idle search
  assign own_req = |(req & gnt);
  assign pending = |(req & ~gnt);
  assign preempt = own_req && pending && hold_cnt == HW'(MAX_HOLD - 1);
  assign busy    = |gnt;

  // ownership FSM: grant, hand over on release or hold expiry, count contended tenure
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= C0;
      last     <= C3;
      hold_cnt <= '0;
    end else if (!own_req || preempt) begin
      hold_cnt <= '0;
      if (found) begin
        state <= OWN;
        gnt   <= 4'b0001 << idx;
        sel   <= idx;
        last  <= idx;
      end else begin
        state <= IDLE;
        gnt   <= 4'b0000;
      end
    end else begin
      hold_cnt <= pending ? hold_cnt + HW'(1) : '0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux4_1 u_mux (
      .d({in3[i], in2[i], in1[i], in0[i]}),
      .s(sel),
      .y(data_out[i])
    );
  end

endmodule

// File: tb/tb_arb4_ctrl.sv
// tb_arb4_ctrl: table-driven and sequence checks of the round-robin arbiter via a scoreboard
module tb_arb4_ctrl;

  typedef struct packed {
    logic       r;
    logic [3:0] q;
    logic [3:0] g;
    logic [1:0] s;
  } vec_t;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [15:0] pay [4];
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] data_out;

  int passed = 0;
  int total  = 0;

  vec_t vt[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  initial begin
    pay[0] = 16'h1A01;
    pay[1] = 16'h2B12;
    pay[2] = 16'h3C23;
    pay[3] = 16'h4D34;
  end

  arb4_ctrl #(.WIDTH(16), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .in0     (pay[0]),
    .in1     (pay[1]),
    .in2     (pay[2]),
    .in3     (pay[3]),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .data_out(data_out)
  );

  function automatic vec_t v(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] s);
    return '{r, q, g, s};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] s, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = q;
    sb.push_back('{g, s});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp({nm, ".gnt"}, 32'(gnt), 32'(e.g));
    cmp({nm, ".sel"}, 32'(sel), 32'(e.s));
    cmp({nm, ".busy"}, 32'(busy), 32'(|e.g));
    cmp({nm, ".data"}, 32'(data_out), 32'(pay[e.s]));
  endtask

  initial begin
    vt.push_back(v(1, 4'b0000, 4'b0000, 2'd0));
    vt.push_back(v(0, 4'b0100, 4'b0100, 2'd2));
    vt.push_back(v(0, 4'b0000, 4'b0000, 2'd2));
    vt.push_back(v(1, 4'b0000, 4'b0000, 2'd0));
    vt.push_back(v(0, 4'b1111, 4'b0001, 2'd0));
    vt.push_back(v(0, 4'b1111, 4'b0001, 2'd0));
    vt.push_back(v(0, 4'b1111, 4'b0001, 2'd0));
    vt.push_back(v(0, 4'b1110, 4'b0010, 2'd1));
    vt.push_back(v(0, 4'b1110, 4'b0010, 2'd1));
    vt.push_back(v(0, 4'b1110, 4'b0010, 2'd1));
    vt.push_back(v(0, 4'b1100, 4'b0100, 2'd2));
    vt.push_back(v(0, 4'b1100, 4'b0100, 2'd2));
    vt.push_back(v(0, 4'b1100, 4'b0100, 2'd2));
    vt.push_back(v(0, 4'b1000, 4'b1000, 2'd3));
    vt.push_back(v(0, 4'b1000, 4'b1000, 2'd3));
    vt.push_back(v(0, 4'b1000, 4'b1000, 2'd3));
    vt.push_back(v(0, 4'b0000, 4'b0000, 2'd3));
    vt.push_back(v(0, 4'b0100, 4'b0100, 2'd2));
    vt.push_back(v(0, 4'b0101, 4'b0100, 2'd2));
    vt.push_back(v(0, 4'b0001, 4'b0001, 2'd0));
    vt.push_back(v(0, 4'b0000, 4'b0000, 2'd0));
    vt.push_back(v(0, 4'b1011, 4'b0010, 2'd1));
    vt.push_back(v(0, 4'b0000, 4'b0000, 2'd1));
    vt.push_back(v(0, 4'b0010, 4'b0010, 2'd1));
    vt.push_back(v(1, 4'b0010, 4'b0000, 2'd0));
    vt.push_back(v(0, 4'b0010, 4'b0010, 2'd1));
    vt.push_back(v(0, 4'b0000, 4'b0000, 2'd1));
    vt.push_back(v(1, 4'b0000, 4'b0000, 2'd0));
    vt.push_back(v(0, 4'b1001, 4'b0001, 2'd0));
    vt.push_back(v(0, 4'b0000, 4'b0000, 2'd0));
    foreach (vt[n]) step(vt[n].r, vt[n].q, vt[n].g, vt[n].s, $sformatf("vec%0d", n));
    step(1, 4'b0000, 4'b0000, 2'd0, "alt_rst");
    for (int t = 0; t < 40; t++)
      step(0, 4'b0011, ((t / 8) % 2) != 0 ? 4'b0010 : 4'b0001, ((t / 8) % 2) != 0 ? 2'd1 : 2'd0, $sformatf("alt%0d", t));
    step(0, 4'b0000, 4'b0000, 2'd0, "alt_end");
    step(1, 4'b0000, 4'b0000, 2'd0, "solo_rst");
    for (int t = 0; t < 21; t++) step(0, 4'b1000, 4'b1000, 2'd3, $sformatf("solo%0d", t));
    for (int t = 0; t < 7; t++) step(0, 4'b1010, 4'b1000, 2'd3, $sformatf("wait%0d", t));
    step(0, 4'b1010, 4'b0010, 2'd1, "handover");
    step(0, 4'b0000, 4'b0000, 2'd1, "solo_end");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
